// File: rtl/multicycle_control.sv
// Main control FSM for a multi-cycle RV32I core.
// Sequences the shared ALU, memory port, instruction register and register
// file. Outputs are decoded combinationally from the current state. They are
// qualified by mem_ready, zero and funct3 where the instruction needs it.
module multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic [2:0] ImmSrc,
    output logic       instr_retired,
    output logic       illegal_instr
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_JALR     = 4'd10,
        S_BRANCH   = 4'd11,
        S_LUI      = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;

    // State register: asynchronous clear back to FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= state_t'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection from current state, opcode and memory handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_BRANCH:   state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_FETCH;
        endcase
    end

    // Per-state datapath steering and strobes; anything unset stays 0 / add
    always_comb begin
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        RegWrite      = 1'b0;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                pc_update = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                MemWrite      = 1'b1;
                instr_retired = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b00;
                alu_op  = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA       = 2'b10;
                ALUSrcB       = 2'b00;
                alu_op        = 2'b01;
                branch        = 1'b1;
                instr_retired = 1'b1;
            end
            S_LUI: begin
                ResultSrc     = 2'b11;
                RegWrite      = 1'b1;
                instr_retired = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_instr = 1'b1;
            end
            default: begin
                alu_op = 2'b00;
            end
        endcase
    end

    // PC load: unconditional updates plus taken branches (beq on zero, bne on !zero)
    always_comb begin
        PCWrite = pc_update | (branch & (zero ^ funct3[0]));
    end

    // ALU operation decode from ALUOp, funct3 and funct7b5
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  ALUControl = ALU_SLL;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b011:  ALUControl = ALU_SLTU;
                    3'b100:  ALUControl = ALU_XOR;
                    3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  ALUControl = ALU_OR;
                    default: ALUControl = ALU_AND;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // Immediate format select, decoded from the opcode in every state
    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_LUI:    ImmSrc = 3'b011;
            OP_JAL:    ImmSrc = 3'b100;
            default:   ImmSrc = 3'b000;
        endcase
    end

endmodule
